// File: rtl/ascon_round_sequencer.sv
// Round sequencer for one ASCON permutation (p^a or p^b) driving an external 4-bit round counter.
// Optional macro ASCON_SEQ_CHECK_EN adds a shadow counter and a sticky err_o on counter mismatch.
module ascon_round_sequencer #(
  parameter int NR_A  = 12,
  parameter int NR_B  = 6,
  parameter int CPT_W = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [CPT_W-1:0] cpt_i,
  output logic             en_cpt_o,
  output logic             init_cpt_o,
  output logic             ready_o,
  output logic             round_en_o,
  output logic             first_round_o,
  output logic [CPT_W-1:0] round_idx_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  localparam logic [CPT_W-1:0] LAST_A = CPT_W'(NR_A - 1);
  localparam logic [CPT_W-1:0] LAST_B = CPT_W'(NR_B - 1);
  localparam logic [CPT_W-1:0] OFS_B  = CPT_W'(NR_A - NR_B);

  state_t           state;
  logic             mode;
  logic             last_round;
  logic [CPT_W-1:0] ofs;

  assign last_round = (cpt_i == (mode ? LAST_B : LAST_A));
  assign ofs        = mode ? OFS_B : '0;

  // Control outputs are registered together with the state they decode.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      mode       <= 1'b0;
      ready_o    <= 1'b1;
      en_cpt_o   <= 1'b0;
      init_cpt_o <= 1'b0;
      round_en_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= INIT;
            mode       <= mode_i;
            ready_o    <= 1'b0;
            en_cpt_o   <= 1'b1;
            init_cpt_o <= 1'b1;
          end
        end
        INIT: begin
          state      <= RUN;
          init_cpt_o <= 1'b0;
          round_en_o <= 1'b1;
        end
        RUN: begin
          if (last_round) begin
            state      <= DONE;
            en_cpt_o   <= 1'b0;
            round_en_o <= 1'b0;
            done_o     <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          done_o  <= 1'b0;
          ready_o <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          ready_o    <= 1'b1;
          en_cpt_o   <= 1'b0;
          init_cpt_o <= 1'b0;
          round_en_o <= 1'b0;
          done_o     <= 1'b0;
        end
      endcase
    end
  end

  // round_en_o is high exactly in RUN, so it gates the counter-derived outputs.
  assign round_idx_o   = round_en_o ? (cpt_i + ofs) : '0;
  assign first_round_o = round_en_o && (cpt_i == '0);

`ifdef ASCON_SEQ_CHECK_EN
  logic [CPT_W-1:0] shadow;
  logic             err;

  always_ff @(posedge clock_i) begin
    if (init_cpt_o) begin
      shadow <= '0;
    end else if (round_en_o) begin
      shadow <= shadow + CPT_W'(1);
    end
  end

  // Sticky until reset; the sequence itself is not disturbed by a mismatch.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      err <= 1'b0;
    end else if (round_en_o && (cpt_i != shadow)) begin
      err <= 1'b1;
    end
  end

  assign err_o = err;
`else
  assign err_o = 1'b0;
`endif

endmodule
